// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : Multi-cycle byte/half/word load-store stage in front of a
//           word-indexed data memory (read-modify-write for sub-word stores).
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] mem_adr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam logic [WIDTH-1:0] MEM_WORDS_W = WIDTH'(MEM_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] store_data_q, store_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [WIDTH-1:0] mem_adr_q, mem_adr_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;

  logic             req_misaligned;
  logic             req_out_of_range;
  logic             req_illegal;
  logic             req_error;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] merge_word;

  // Request validation works on the live inputs so the error path needs no extra cycle.
  always_comb begin
    req_misaligned = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
      req_misaligned = 1'b1;
    if (funct3 == F3_W && addr[1:0] != 2'b00)
      req_misaligned = 1'b1;

    req_out_of_range = {2'b00, addr[WIDTH-1:2]} >= MEM_WORDS_W;

    case (funct3)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = is_store;
      default:          req_illegal = 1'b1;
    endcase

    req_error = req_misaligned | req_out_of_range | req_illegal;
  end

  always_comb begin
    rd_byte = mem_rd[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (funct3_q)
      F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_ext = {24'h000000, rd_byte};
      F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_ext = {16'h0000, rd_half};
      default: load_ext = mem_rd;
    endcase

    // Sub-word store: overwrite only the addressed lane, keep the rest of the read word.
    merge_word = mem_rd;
    if (funct3_q == F3_B)
      merge_word[{off_q, 3'b000} +: 8] = store_data_q[7:0];
    else
      merge_word[{off_q[1], 4'b0000} +: 16] = store_data_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    mem_adr_d    = mem_adr_q;
    mem_wd_d     = mem_wd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          off_d        = addr[1:0];
          store_data_d = store_data;
          mem_adr_d    = {2'b00, addr[WIDTH-1:2]};
          if (req_error) begin
            state_d = S_ERR;
          end else if (is_store && funct3 == F3_W) begin
            mem_wd_d = store_data;
            state_d  = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (is_store_q) begin
          mem_wd_d = merge_word;
          state_d  = S_WRITE;
        end else begin
          load_data_d = load_ext;
          state_d     = S_FIN;
        end
      end
      S_WRITE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they register as Moore outputs.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN) || (state_d == S_ERR);
    err_d    = (state_d == S_ERR);
    mem_we_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      store_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_data_q  <= '0;
      mem_adr_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      store_data_q <= store_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      load_data_q  <= load_data_d;
      mem_adr_q    <= mem_adr_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_adr   = mem_adr_q;
  assign mem_we    = mem_we_q;
  assign mem_wd    = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed self-checking bench for load_store_unit against a
//           request-level memory/extension model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, err, mem_we;
  logic [31:0] load_data, mem_adr, mem_wd, mem_rd;

  logic        poke_en = 1'b0;
  logic [8:0]  poke_idx = 9'd0;
  logic [31:0] poke_val = 32'h0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] exp_ld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .MEM_WORDS(512)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_adr < 32'd512) ? mem[mem_adr[8:0]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_val;
    else if (mem_we && mem_adr < 32'd512)
      mem[mem_adr[8:0]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[8:0];
    poke_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Request-level reference: error decision, latency, resulting load value and written word.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, output logic e, output int lat,
                                output logic [31:0] newld, output logic [31:0] wdat);
    int          word;
    int          k;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    word = int'(a >> 2);
    k    = int'(a % 4);
    e = (f3 == 3 || f3 == 6 || f3 == 7) || (st && (f3 == 4 || f3 == 5)) ||
        ((f3 == 1 || f3 == 5) && (k % 2 != 0)) || (f3 == 2 && k != 0) ||
        ((a >> 2) >= 512);
    newld = exp_ld;
    wdat  = 32'h0;
    lat   = 1;
    if (!e) begin
      w = ref_mem[word];
      b = w[8*k +: 8];
      h = w[16*(k/2) +: 16];
      if (!st) begin
        lat = 2;
        case (f3)
          3'd0:    newld = {{24{b[7]}}, b};
          3'd4:    newld = {24'h0, b};
          3'd1:    newld = {{16{h[15]}}, h};
          3'd5:    newld = {16'h0, h};
          default: newld = w;
        endcase
      end else if (f3 == 3'd2) begin
        lat  = 2;
        wdat = sd;
      end else begin
        lat  = 3;
        wdat = w;
        if (f3 == 3'd0) wdat[8*k +: 8] = sd[7:0];
        else            wdat[16*(k/2) +: 16] = sd[15:0];
      end
    end
  endfunction

  // Issues one request at a negedge and checks every output each cycle until back in IDLE.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic hold, input logic chk_lit,
                        input logic [31:0] lit);
    logic        e;
    int          lat;
    logic [31:0] newld, wdat;
    logic        we_cyc;
    model(st, f3, a, sd, e, lat, newld, wdat);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (!hold || c >= lat) start = 1'b0;
      if (hold) begin
        addr       = a ^ 32'h4;
        store_data = ~sd;
      end
      we_cyc = !e && st && (c == lat - 1);
      chk("busy",   32'(busy),   32'(c <= lat));
      chk("done",   32'(done),   32'(c == lat));
      chk("err",    32'(err),    32'(c == lat && e));
      chk("mem_we", 32'(mem_we), 32'(we_cyc));
      if (c <= lat) chk("mem_adr", mem_adr, a >> 2);
      if (we_cyc) chk("mem_wd", mem_wd, wdat);
      if (c == lat) begin
        chk("load_data", load_data, newld);
        if (chk_lit) chk("load_lit", load_data, lit);
      end
    end
    exp_ld = newld;
    if (!e && st) ref_mem[a >> 2] = wdat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_ld = 32'h0;
    #2;
    chk("rst_busy",      32'(busy),   32'h0);
    chk("rst_done",      32'(done),   32'h0);
    chk("rst_err",       32'(err),    32'h0);
    chk("rst_mem_we",    32'(mem_we), 32'h0);
    chk("rst_load_data", load_data,   32'h0);
    chk("rst_mem_adr",   mem_adr,     32'h0);
    chk("rst_mem_wd",    mem_wd,      32'h0);

    poke(0, 32'h0000_0000);
    poke(1, 32'h1234_5678);
    poke(2, 32'h0000_0008);
    poke(3, 32'h0000_0009);
    poke(4, 32'h0000_0000);
    poke(5, 32'h80FF_7F01);
    poke(7, 32'h1111_1111);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain and sub-word loads
    do_req(1'b0, 3'd2, 32'h08, 32'h0, 1'b0, 1'b1, 32'h0000_0008);
    do_req(1'b0, 3'd0, 32'h17, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h17, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    do_req(1'b0, 3'd1, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0000_7F01);
    do_req(1'b0, 3'd1, 32'h16, 32'h0, 1'b0, 1'b1, 32'hFFFF_80FF);
    do_req(1'b0, 3'd5, 32'h16, 32'h0, 1'b0, 1'b1, 32'h0000_80FF);
    do_req(1'b0, 3'd0, 32'h15, 32'h0, 1'b0, 1'b1, 32'h0000_007F);

    // Read-modify-write stores
    do_req(1'b1, 3'd0, 32'h0D, 32'h1234_56AB, 1'b0, 1'b0, 32'h0);
    chk("sb_word3", mem[3], 32'h0000_AB09);
    do_req(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0, 1'b1, 32'h0000_AB09);
    do_req(1'b1, 3'd1, 32'h16, 32'h5555_CAFE, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 3'd2, 32'h14, 32'h0, 1'b0, 1'b1, 32'hCAFE_7F01);

    // Full-word store with start held high while busy
    do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("sw_word4", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Error requests leave memory and load_data alone
    do_req(1'b0, 3'd2, 32'h06,  32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b1, 3'd1, 32'h03,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h800, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd7, 32'h00,  32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b1, 3'd4, 32'h00,  32'hFF, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("err_word0", mem[0], 32'h0000_0000);

    // Asynchronous reset while the write is pending
    start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h1C; store_data = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_mem_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mid_busy",   32'(busy),   32'h0);
    chk("rst_mid_done",   32'(done),   32'h0);
    @(negedge clk);
    rst    = 1'b0;
    exp_ld = 32'h0;
    chk("rst_word7", mem[7], 32'h1111_1111);
    chk("rst_mid_load_data", load_data, 32'h0);
    @(negedge clk);
    do_req(1'b0, 3'd2, 32'h1C, 32'h0, 1'b0, 1'b1, 32'h1111_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
